// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC sample scheduler.
// State encoding and the offset-binary midscale helper.
package dac_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RAMP
  } state_t;

  function automatic logic [31:0] midscale(input int msbi);
    return 32'd1 << msbi;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO holding granted samples.
// Flush empties it in one cycle and wins over push/pop.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp_q;
  logic [AW-1:0]    rp_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign level   = cnt_q;
  assign dout    = mem[rp_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wp_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push)
        wp_q <= wp_q + AW'(1);
      if (do_pop)
        rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW + 1)'(do_push)
                     - (AW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Two-requester sample scheduler feeding a sigma-delta DAC:
// round-robin arbiter, rate divider and play/ramp FSM.
module dac_sample_scheduler
  import dac_sched_pkg::*;
#(
  parameter int            MSBI  = 15,
  parameter int            DIV   = 4,
  parameter logic [MSBI:0] STEP  = 16'h1000,
  parameter int            DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   ENABLE,
  input  logic                   REQ0_VALID,
  input  logic [MSBI:0]          REQ0_DATA,
  output logic                   REQ0_READY,
  input  logic                   REQ1_VALID,
  input  logic [MSBI:0]          REQ1_DATA,
  output logic                   REQ1_READY,
  output logic [MSBI:0]          DAC_DATA,
  output logic                   DAC_CEN,
  output logic                   UNDERFLOW,
  output logic [$clog2(DEPTH):0] LEVEL
);
  localparam int W = MSBI + 1;
  localparam logic [W-1:0] MID = W'(midscale(MSBI));

  state_t       state_q;
  logic [15:0]  div_q;
  logic         cen;
  logic         last_q;
  logic         run_en;
  logic         grant0;
  logic         grant1;
  logic         push;
  logic         pop;
  logic         flush;
  logic         full;
  logic         empty;
  logic [W-1:0] push_data;
  logic [W-1:0] head;
  logic [W-1:0] ramp_nxt;
  logic [W:0]   d_ext;
  logic [W:0]   m_ext;
  logic [W:0]   s_ext;

  assign cen     = (div_q == 16'(DIV - 1));
  assign DAC_CEN = cen;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      div_q <= '0;
    else
      div_q <= cen ? '0 : div_q + 16'd1;
  end

  // last_q = 1 means requester 1 was served last
  assign run_en = (state_q == RUN) && ENABLE;
  assign grant0 = REQ0_VALID && (!REQ1_VALID || last_q);
  assign grant1 = REQ1_VALID && (!REQ0_VALID || !last_q);

  assign REQ0_READY = run_en && !full && grant0;
  assign REQ1_READY = run_en && !full && grant1;

  assign push = (REQ0_VALID && REQ0_READY)
             || (REQ1_VALID && REQ1_READY);
  assign push_data = REQ1_READY ? REQ1_DATA : REQ0_DATA;
  assign pop = (state_q == RUN) && cen && !empty;
  assign flush = (state_q == IDLE)
              || ((state_q == RUN) && !ENABLE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      last_q <= 1'b1;
    else if (push)
      last_q <= REQ1_READY;
  end

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .flush (flush),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (LEVEL)
  );

  // one extra bit so the gap to midscale never wraps
  assign d_ext = {1'b0, DAC_DATA};
  assign m_ext = {1'b0, MID};
  assign s_ext = {1'b0, STEP};

  always_comb begin
    ramp_nxt = DAC_DATA;
    if (d_ext > m_ext)
      ramp_nxt = (d_ext - m_ext <= s_ext)
               ? MID : DAC_DATA - STEP;
    else if (d_ext < m_ext)
      ramp_nxt = (m_ext - d_ext <= s_ext)
               ? MID : DAC_DATA + STEP;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      DAC_DATA  <= MID;
      UNDERFLOW <= 1'b0;
    end else begin
      UNDERFLOW <= 1'b0;
      unique case (state_q)
        IDLE: begin
          DAC_DATA <= MID;
          if (ENABLE)
            state_q <= RUN;
        end
        RUN: begin
          if (pop)
            DAC_DATA <= head;
          UNDERFLOW <= cen && empty;
          if (!ENABLE)
            state_q <= RAMP;
        end
        RAMP: begin
          if (ENABLE)
            state_q <= RUN;
          else if (DAC_DATA == MID)
            state_q <= IDLE;
          else if (cen)
            DAC_DATA <= ramp_nxt;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Bench for dac_sample_scheduler: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_dac_sample_scheduler;
  import dac_sched_pkg::*;

  localparam int DIV   = 4;
  localparam int DEPTH = 4;
  localparam int STEPI = 'h1000;
  localparam logic [15:0] MID = 16'h8000;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic        REQ0_VALID = 1'b0;
  logic        REQ1_VALID = 1'b0;
  logic [15:0] REQ0_DATA = '0;
  logic [15:0] REQ1_DATA = '0;
  logic        REQ0_READY;
  logic        REQ1_READY;
  logic [15:0] DAC_DATA;
  logic        DAC_CEN;
  logic        UNDERFLOW;
  logic [2:0]  LEVEL;

  dac_sample_scheduler #(
    .MSBI  (15),
    .DIV   (DIV),
    .STEP  (16'h1000),
    .DEPTH (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .ENABLE     (ENABLE),
    .REQ0_VALID (REQ0_VALID),
    .REQ0_DATA  (REQ0_DATA),
    .REQ0_READY (REQ0_READY),
    .REQ1_VALID (REQ1_VALID),
    .REQ1_DATA  (REQ1_DATA),
    .REQ1_READY (REQ1_READY),
    .DAC_DATA   (DAC_DATA),
    .DAC_CEN    (DAC_CEN),
    .UNDERFLOW  (UNDERFLOW),
    .LEVEL      (LEVEL)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;

  // reference model: 0 idle, 1 play, 2 ramp
  logic [15:0] m_q[$];
  int          m_mode;
  int          m_div;
  int          m_last;
  logic [15:0] m_dac;
  logic        m_uf;
  logic        m_tick;
  logic        m_r0;
  logic        m_r1;

  function automatic void m_reset();
    m_q.delete();
    m_mode = 0;
    m_div  = 0;
    m_last = 1;
    m_dac  = MID;
    m_uf   = 1'b0;
  endfunction

  function automatic void m_comb();
    int g;
    g = -1;
    if (REQ0_VALID && REQ1_VALID)
      g = (m_last == 1) ? 0 : 1;
    else if (REQ0_VALID)
      g = 0;
    else if (REQ1_VALID)
      g = 1;
    m_tick = (m_div == DIV - 1);
    m_r0 = (m_mode == 1) && ENABLE
        && (m_q.size() < DEPTH) && (g == 0);
    m_r1 = (m_mode == 1) && ENABLE
        && (m_q.size() < DEPTH) && (g == 1);
  endfunction

  function automatic logic [15:0] ramp(logic [15:0] v);
    int d;
    d = int'(v) - int'(MID);
    if (d > STEPI) return v - 16'h1000;
    if (d < -STEPI) return v + 16'h1000;
    return MID;
  endfunction

  task automatic step();
    logic [15:0] pd;
    logic        pv;
    logic        t;
    m_comb();
    t  = m_tick;
    pv = (m_r0 && REQ0_VALID) || (m_r1 && REQ1_VALID);
    pd = m_r1 ? REQ1_DATA : REQ0_DATA;
    @(posedge CLK);
    m_uf = 1'b0;
    case (m_mode)
      0: begin
        m_q.delete();
        m_dac = MID;
        if (ENABLE) m_mode = 1;
      end
      1: begin
        m_uf = t && (m_q.size() == 0);
        if (t && m_q.size() > 0)
          m_dac = m_q.pop_front();
        if (pv) begin
          m_q.push_back(pd);
          m_last = m_r1 ? 1 : 0;
        end
        if (!ENABLE) begin
          m_q.delete();
          m_mode = 2;
        end
      end
      default: begin
        if (ENABLE) m_mode = 1;
        else if (m_dac == MID) m_mode = 0;
        else if (t) m_dac = ramp(m_dac);
      end
    endcase
    m_div = t ? 0 : m_div + 1;
    m_tick = t;
    #1;
  endtask

  task automatic do_reset();
    RESET_N    = 1'b0;
    ENABLE     = 1'b0;
    REQ0_VALID = 1'b0;
    REQ1_VALID = 1'b0;
    m_reset();
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    int n;
    RESET_N = 1'b0;
    m_reset();
    #12;
    checks++;
    if (DAC_DATA !== 16'h8000)
      $display("FAIL rst_dac got %h want 8000", DAC_DATA);
    else passed++;
    checks++;
    if ({DAC_CEN, UNDERFLOW} !== 2'b00)
      $display("FAIL rst_cen_uf got %b want 00",
               {DAC_CEN, UNDERFLOW});
    else passed++;
    checks++;
    if ({REQ0_READY, REQ1_READY} !== 2'b00)
      $display("FAIL rst_ready got %b want 00",
               {REQ0_READY, REQ1_READY});
    else passed++;
    checks++;
    if (LEVEL !== 3'd0)
      $display("FAIL rst_level got %0d want 0", LEVEL);
    else passed++;
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    n = 0;
    while (DAC_CEN !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n != DIV - 1)
      $display("FAIL rst_div edges got %0d want %0d",
               n, DIV - 1);
    else passed++;
  endtask

  task automatic test_playback();
    logic [15:0] vals[4];
    int          tc[4];
    int          nt;
    int          sent;
    logic        acc;
    do_reset();
    ENABLE = 1'b1;
    REQ0_VALID = 1'b1;
    REQ0_DATA = 16'hA000;
    nt = 0;
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      m_comb();
      checks++;
      if (DAC_CEN !== m_tick)
        $display("FAIL play_cen got %b want %b",
                 DAC_CEN, m_tick);
      else passed++;
      acc = m_r0 && REQ0_VALID;
      step();
      if (acc) begin
        sent++;
        if (sent == 1) REQ0_DATA = 16'hA000 ^ 16'hC000;
        if (sent == 2) REQ0_VALID = 1'b0;
      end
      if (m_tick && nt < 4) begin
        vals[nt] = DAC_DATA;
        tc[nt] = c;
        nt++;
      end
    end
    checks++;
    if (nt < 3)
      $display("FAIL play_ticks got %0d want 3+", nt);
    else passed++;
    checks++;
    if (vals[0] !== 16'hA000 || vals[1] !== 16'h6000)
      $display("FAIL play_seq got %h %h want a000 6000",
               vals[0], vals[1]);
    else passed++;
    checks++;
    if (tc[1] - tc[0] != DIV)
      $display("FAIL play_period got %0d want %0d",
               tc[1] - tc[0], DIV);
    else passed++;
  endtask

  task automatic test_arbitration();
    logic [15:0] seq[$];
    logic [15:0] want;
    int          saw_full;
    do_reset();
    ENABLE = 1'b1;
    REQ0_VALID = 1'b1;
    REQ1_VALID = 1'b1;
    REQ0_DATA = 16'h1111;
    REQ1_DATA = 16'h2222;
    saw_full = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      m_comb();
      if (m_q.size() == DEPTH) begin
        saw_full++;
        checks++;
        if ({REQ0_READY, REQ1_READY} !== 2'b00)
          $display("FAIL arb_full_ready got %b want 00",
                   {REQ0_READY, REQ1_READY});
        else passed++;
      end
      step();
      if (m_tick) seq.push_back(DAC_DATA);
    end
    checks++;
    if (saw_full == 0 || seq.size() < 8)
      $display("FAIL arb_cover full %0d ticks %0d want >0 >=8",
               saw_full, seq.size());
    else passed++;
    foreach (seq[i]) begin
      want = (i % 2 == 0) ? 16'h1111 : 16'h2222;
      checks++;
      if (seq[i] !== want)
        $display("FAIL arb_order[%0d] got %h want %h",
                 i, seq[i], want);
      else passed++;
    end
  endtask

  task automatic test_underflow();
    int pulses;
    do_reset();
    ENABLE = 1'b1;
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      step();
      if (UNDERFLOW === 1'b1) pulses++;
      checks++;
      if (UNDERFLOW !== m_tick || DAC_DATA !== 16'h8000)
        $display("FAIL uf_cycle%0d got %b/%h want %b/8000",
                 c, UNDERFLOW, DAC_DATA, m_tick);
      else passed++;
    end
    checks++;
    if (pulses != 6)
      $display("FAIL uf_count got %0d want 6", pulses);
    else passed++;
  endtask

  task automatic load_a800();
    int n;
    do_reset();
    ENABLE = 1'b1;
    REQ0_VALID = 1'b1;
    REQ0_DATA = 16'hA800;
    step();
    step();
    REQ0_VALID = 1'b0;
    n = 0;
    while (DAC_DATA !== 16'hA800 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n >= 20)
      $display("FAIL load_a800 timeout got %h want a800",
               DAC_DATA);
    else passed++;
  endtask

  task automatic test_ramp();
    logic [15:0] vals[$];
    load_a800();
    ENABLE = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step();
      if (m_tick) vals.push_back(DAC_DATA);
      checks++;
      if (UNDERFLOW !== 1'b0)
        $display("FAIL ramp_uf got %b want 0", UNDERFLOW);
      else passed++;
    end
    checks++;
    if (vals.size() < 3)
      $display("FAIL ramp_ticks got %0d want 3+", vals.size());
    else if (vals[0] !== 16'h9800 || vals[1] !== 16'h8800
             || vals[2] !== 16'h8000)
      $display("FAIL ramp_seq got %h %h %h want 9800 8800 8000",
               vals[0], vals[1], vals[2]);
    else passed++;
    checks++;
    if (dut.state_q !== IDLE || LEVEL !== 3'd0)
      $display("FAIL ramp_end got %s/%0d want IDLE/0",
               dut.state_q.name(), LEVEL);
    else passed++;
  endtask

  task automatic test_reenable();
    int n;
    load_a800();
    ENABLE = 1'b0;
    n = 0;
    while (DAC_DATA !== 16'h9800 && n < 12) begin
      step();
      n++;
    end
    checks++;
    if (n >= 12)
      $display("FAIL reen_wait got %h want 9800", DAC_DATA);
    else passed++;
    ENABLE = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (DAC_DATA !== 16'h9800)
        $display("FAIL reen_hold got %h want 9800", DAC_DATA);
      else passed++;
    end
    checks++;
    if (dut.state_q !== RUN)
      $display("FAIL reen_state got %s want RUN",
               dut.state_q.name());
    else passed++;
    REQ1_VALID = 1'b1;
    REQ1_DATA = 16'h1234;
    step();
    REQ1_VALID = 1'b0;
    n = 0;
    while (DAC_DATA === 16'h9800 && n < 12) begin
      step();
      n++;
    end
    checks++;
    if (DAC_DATA !== 16'h1234)
      $display("FAIL reen_pop got %h want 1234", DAC_DATA);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    ENABLE = 1'b1;
    REQ0_VALID = 1'b1;
    REQ0_DATA = 16'h4321;
    n = 0;
    while (m_q.size() != 3 && n < 20) begin
      step();
      n++;
    end
    REQ0_VALID = 1'b0;
    checks++;
    if (LEVEL !== 3'd3)
      $display("FAIL rmid_level got %0d want 3", LEVEL);
    else passed++;
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (DAC_DATA !== 16'h8000 || LEVEL !== 3'd0)
      $display("FAIL rmid_out got %h/%0d want 8000/0",
               DAC_DATA, LEVEL);
    else passed++;
    checks++;
    if ({REQ0_READY, REQ1_READY} !== 2'b00
        || dut.state_q !== IDLE)
      $display("FAIL rmid_idle got %b/%s want 00/IDLE",
               {REQ0_READY, REQ1_READY}, dut.state_q.name());
    else passed++;
    m_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    n = 0;
    while (DAC_CEN !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n != DIV - 1)
      $display("FAIL rmid_div got %0d want %0d", n, DIV - 1);
    else passed++;
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 2) ENABLE = ~ENABLE;
      REQ0_VALID = 1'($urandom_range(0, 1));
      REQ1_VALID = 1'($urandom_range(0, 1));
      REQ0_DATA = 16'($urandom);
      REQ1_DATA = 16'($urandom);
      #1;
      m_comb();
      checks++;
      if ({REQ0_READY, REQ1_READY, DAC_CEN}
          !== {m_r0, m_r1, m_tick}) begin
        if (errs++ < 10)
          $display("FAIL rnd_comb c%0d got %b want %b", c,
                   {REQ0_READY, REQ1_READY, DAC_CEN},
                   {m_r0, m_r1, m_tick});
      end else passed++;
      step();
      checks++;
      if (DAC_DATA !== m_dac || UNDERFLOW !== m_uf
          || LEVEL !== 3'(m_q.size())) begin
        if (errs++ < 10)
          $display("FAIL rnd_reg c%0d got %h/%b/%0d want %h/%b/%0d",
                   c, DAC_DATA, UNDERFLOW, LEVEL,
                   m_dac, m_uf, m_q.size());
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_playback();
    test_arbitration();
    test_underflow();
    test_ramp();
    test_reenable();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dac_sample_scheduler.md
DAC_SAMPLE_SCHEDULER -- requirements
Module: dac_sample_scheduler

Interface
REQ-001 Parameter MSBI, default 15: sample MSB index; samples are offset binary, excess 2**MSBI.
REQ-002 Parameter DIV, default 4: sample-rate divider, CLK cycles per DAC_CEN pulse, legal range 2..65535.
REQ-003 Parameter STEP, default 16'h1000: mute-ramp increment per sample tick.
REQ-004 Parameter DEPTH, default 4: shared FIFO depth, power of two, minimum 2.
REQ-005 CLK  in  1  sole clock.
REQ-006 RESET_N  in  1  asynchronous, active-low reset.
REQ-007 ENABLE  in  1  level; 1 = play, 0 = ramp to silence.
REQ-008 REQ0_VALID / REQ1_VALID  in  1  requester sample valid.
REQ-009 REQ0_DATA / REQ1_DATA  in  MSBI+1  requester sample.
REQ-010 REQ0_READY / REQ1_READY  out  1  sample accepted when VALID and READY are both 1.
REQ-011 DAC_DATA  out  MSBI+1  registered sample feeding the sigma-delta DACin.
REQ-012 DAC_CEN  out  1  one-cycle sample tick.
REQ-013 UNDERFLOW  out  1  one-cycle pulse on a tick that finds the FIFO empty in RUN.
REQ-014 LEVEL  out  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-015 Divider counts 0..DIV-1 and wraps; DAC_CEN = 1 exactly in the cycle the count equals DIV-1; the divider runs in every state.
REQ-016 FSM states are IDLE, RUN and RAMP.
REQ-017 IDLE: DAC_DATA holds 2**MSBI (midscale), both READY outputs are 0, FIFO is held empty; ENABLE=1 moves to RUN on the next cycle.
REQ-018 RUN: READYi = 1 iff the FIFO is not full and requester i holds the grant; at most one push per cycle.
REQ-019 Arbitration is round-robin: with one VALID, that requester is granted; with both VALID, the requester not served last is granted; the last-served pointer updates only on an actual push; the pointer resets to requester 1, so requester 0 wins the first conflict.
REQ-020 Full FIFO: both READY outputs are 0, even when a pop occurs in the same cycle.
REQ-021 RUN tick with FIFO non-empty: DAC_DATA takes the FIFO head on the cycle after DAC_CEN, and the head is popped in the DAC_CEN cycle.
REQ-022 RUN tick with FIFO empty: DAC_DATA holds its value and UNDERFLOW pulses in the cycle after DAC_CEN.
REQ-023 A push and a pop in the same cycle leave LEVEL unchanged and the data order intact (FIFO order).
REQ-024 RUN with ENABLE=0: move to RAMP on the next cycle, flush the FIFO on entry (LEVEL=0) and drive both READY outputs to 0.
REQ-025 RAMP tick: DAC_DATA moves toward 2**MSBI by STEP, clamped so it never overshoots; the midscale comparison uses MSBI+2-bit arithmetic with no wrap-around.
REQ-026 RAMP: DAC_DATA equal to 2**MSBI moves to IDLE on the next cycle; ENABLE=1 moves to RUN on the next cycle, keeping the current DAC_DATA.
REQ-027 UNDERFLOW never asserts in IDLE or RAMP.

Reset
REQ-028 RESET_N low asynchronously forces: state IDLE, DAC_DATA = 2**MSBI, DAC_CEN = 0, UNDERFLOW = 0, both READY outputs = 0, LEVEL = 0, divider = 0, round-robin pointer = requester 1.
REQ-029 Reset asserted mid-operation discards FIFO contents; operation restarts from IDLE after release, with the divider counting from 0 on the first rising CLK edge after release.

Structure
REQ-030 Shared package dac_sched_pkg holds the state enum (IDLE, RUN, RAMP) and the midscale constant function of MSBI.
REQ-031 The FIFO is a sub-module sample_fifo (parameters DEPTH and width; push, pop, full, empty, level; asynchronous active-low reset); arbiter, divider and FSM live in the top module.

Verification (MSBI=15, DIV=4, STEP=16'h1000, DEPTH=4)
REQ-032 Reset then ENABLE=1, REQ0 pushes 16'hA000 and 16'h6000 -> DAC_CEN every 4th cycle; DAC_DATA 16'h8000 -> 16'hA000 -> 16'h6000 on successive ticks.
REQ-033 Both requesters valid continuously, REQ0 data 16'h1111, REQ1 data 16'h2222 -> the FIFO and DAC order alternate 1111, 2222, 1111, ...; the READY outputs drop when LEVEL=4.
REQ-034 ENABLE=1 with no pushes -> UNDERFLOW pulses once per tick and DAC_DATA holds 16'h8000.
REQ-035 DAC_DATA=16'hA800, ENABLE dropped -> 16'h9800, 16'h8800, 16'h8000 on successive ticks, then IDLE; LEVEL=0.
REQ-036 ENABLE re-asserted in RAMP at 16'h9800 -> RUN, DAC_DATA holds 16'h9800 until the next FIFO pop.
REQ-037 RESET_N pulsed low mid-RUN with LEVEL=3 -> immediately DAC_DATA=16'h8000, LEVEL=0, both READY outputs 0, state IDLE.
